// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: funct3 codes, FSM states,
// lane masks and the request legality check.
package dmem_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WAIT = 3'd2,
      ST_WR   = 3'd3,
      ST_RESP = 3'd4
   } state_e;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [31:0] LANE_MASK_B = 32'h0000_00FF;
   localparam logic [31:0] LANE_MASK_H = 32'h0000_FFFF;

   // funct3[1:0] gives the access size for both loads and the unsigned load variants.
   function automatic logic req_err(input logic we, input logic [2:0] f3, input logic [1:0] a);
      logic bad_f3;
      logic misal;
      bad_f3 = we ? (f3 > F3_W) : ((f3 == 3'd3) || (f3 >= 3'd6));
      misal  = ((f3[1:0] == 2'd1) && a[0]) || ((f3[1:0] == 2'd2) && (a != 2'b00));
      return bad_f3 | misal;
   endfunction

endpackage

// File: rtl/dmem_lane.sv
// Byte/half lane logic: merges store data into a read word and extracts and
// extends load data from it. Purely combinational.
module dmem_lane
   import dmem_pkg::*;
(
   input  logic [2:0]  iFUNC3,
   input  logic [1:0]  iADDR_LO,
   input  logic [31:0] iRD_WORD,
   input  logic [31:0] iWR_DATA,
   output logic [31:0] oWR_WORD,
   output logic [31:0] oLD_DATA
);

   logic [4:0]  byte_sh;
   logic [4:0]  half_sh;
   logic [7:0]  lane_b;
   logic [15:0] lane_h;

   always_comb begin
      byte_sh = {iADDR_LO, 3'b000};
      half_sh = {iADDR_LO[1], 4'b0000};
      lane_b  = 8'(iRD_WORD >> byte_sh);
      lane_h  = 16'(iRD_WORD >> half_sh);

      oWR_WORD = iWR_DATA;
      case (iFUNC3)
         F3_B:    oWR_WORD = (iRD_WORD & ~(LANE_MASK_B << byte_sh)) | ((iWR_DATA & LANE_MASK_B) << byte_sh);
         F3_H:    oWR_WORD = (iRD_WORD & ~(LANE_MASK_H << half_sh)) | ((iWR_DATA & LANE_MASK_H) << half_sh);
         default: oWR_WORD = iWR_DATA;
      endcase

      oLD_DATA = iRD_WORD;
      case (iFUNC3)
         F3_B:    oLD_DATA = {{24{lane_b[7]}}, lane_b};
         F3_BU:   oLD_DATA = {24'h0, lane_b};
         F3_H:    oLD_DATA = {{16{lane_h[15]}}, lane_h};
         F3_HU:   oLD_DATA = {16'h0, lane_h};
         default: oLD_DATA = iRD_WORD;
      endcase
   end

endmodule

// File: rtl/dmem_ctrl.sv
// Load/store sequencer for a single-port word RAM: one request at a time,
// sub-word stores done as read-modify-write over separate RAM cycles.
module dmem_ctrl #(
   parameter int ADDR_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              iCLK,
   input  logic              iRST,
   input  logic              iREQ_VALID,
   output logic              oREQ_READY,
   input  logic              iREQ_WE,
   input  logic [2:0]        iREQ_FUNC3,
   input  logic [ADDR_W+1:0] iREQ_ADDR,
   input  logic [31:0]       iREQ_WDATA,
   output logic              oRSP_VALID,
   input  logic              iRSP_READY,
   output logic [31:0]       oRSP_RDATA,
   output logic              oRSP_ERR,
   output logic              oRAM_CE,
   output logic              oRAM_RD,
   output logic              oRAM_WR,
   output logic [ADDR_W-1:0] oRAM_ADDR,
   input  logic [31:0]       iRAM_DATA,
   output logic [31:0]       oRAM_DATA
);

   import dmem_pkg::*;

   state_e            state_q, state_d;
   logic              we_q, we_d;
   logic [2:0]        f3_q, f3_d;
   logic [ADDR_W+1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rword_q, rword_d;
   logic              err_q, err_d;
   logic [1:0]        cnt_q, cnt_d;
   logic [31:0]       wr_word;
   logic [31:0]       ld_data;
   logic              rsp_vld;

   dmem_lane u_lane (
      .iFUNC3   (f3_q),
      .iADDR_LO (addr_q[1:0]),
      .iRD_WORD (rword_q),
      .iWR_DATA (wdata_q),
      .oWR_WORD (wr_word),
      .oLD_DATA (ld_data)
   );

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= ST_IDLE;
         we_q    <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rword_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         f3_q    <= f3_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rword_q <= rword_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      f3_d    = f3_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rword_d = rword_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (iREQ_VALID) begin
               we_d    = iREQ_WE;
               f3_d    = iREQ_FUNC3;
               addr_d  = iREQ_ADDR;
               wdata_d = iREQ_WDATA;
               err_d   = req_err(iREQ_WE, iREQ_FUNC3, iREQ_ADDR[1:0]);
               if (err_d)                              state_d = ST_RESP;
               else if (iREQ_WE && iREQ_FUNC3 == F3_W) state_d = ST_WR;
               else                                    state_d = ST_RD;
            end
         end
         ST_RD: begin
            cnt_d   = 2'(RD_LAT - 1);
            state_d = ST_WAIT;
         end
         // Counter runs down to zero; the read word is valid in the last WAIT cycle.
         ST_WAIT: begin
            if (cnt_q == 2'd0) begin
               rword_d = iRAM_DATA;
               state_d = we_q ? ST_WR : ST_RESP;
            end else begin
               cnt_d = cnt_q - 2'd1;
            end
         end
         ST_WR:   state_d = ST_RESP;
         ST_RESP: if (iRSP_READY) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      rsp_vld    = (state_q == ST_RESP);
      oREQ_READY = (state_q == ST_IDLE);
      oRSP_VALID = rsp_vld;
      oRSP_ERR   = rsp_vld & err_q;
      oRSP_RDATA = (rsp_vld && !we_q && !err_q) ? ld_data : 32'h0;
      // Strobes are gated by reset so an abandoned RMW never writes.
      oRAM_CE    = !iRST && ((state_q == ST_RD) || (state_q == ST_WAIT) || (state_q == ST_WR));
      oRAM_RD    = !iRST && (state_q == ST_RD);
      oRAM_WR    = !iRST && (state_q == ST_WR);
      oRAM_ADDR  = addr_q[ADDR_W+1:2];
      oRAM_DATA  = wr_word;
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: two instances (RD_LAT=1 and RD_LAT=2), each
// with its own behavioural RAM.
module tb_dmem_ctrl;

   localparam logic [2:0] F3_B = 3'd0, F3_H = 3'd1, F3_W = 3'd2, F3_BU = 3'd4, F3_HU = 3'd5;

   logic        clk;
   logic        rst       [2];
   logic        req_valid [2];
   logic        req_ready [2];
   logic        req_we    [2];
   logic [2:0]  req_f3    [2];
   logic [9:0]  req_addr  [2];
   logic [31:0] req_wdata [2];
   logic        rsp_valid [2];
   logic        rsp_ready [2];
   logic [31:0] rsp_rdata [2];
   logic        rsp_err   [2];
   logic        ram_ce    [2];
   logic        ram_rd    [2];
   logic        ram_wr    [2];
   logic [7:0]  ram_addr  [2];
   logic [31:0] ram_rdata [2];
   logic [31:0] ram_wdata [2];

   logic [31:0] mem     [2][256];
   logic [31:0] rd_pipe [2][2];
   logic        poke_en [2];
   logic [7:0]  poke_a  [2];
   logic [31:0] poke_v  [2];

   int n_cmp = 0;
   int n_bad = 0;

   int t_rd, t_wr, t_vld, n_rd, n_wr, n_ce;
   logic [31:0] wr_data, rdata;
   logic [7:0]  wr_addr;
   logic        err;

   dmem_ctrl #(.ADDR_W(8), .RD_LAT(1)) u0 (
      .iCLK(clk), .iRST(rst[0]), .iREQ_VALID(req_valid[0]), .oREQ_READY(req_ready[0]),
      .iREQ_WE(req_we[0]), .iREQ_FUNC3(req_f3[0]), .iREQ_ADDR(req_addr[0]), .iREQ_WDATA(req_wdata[0]),
      .oRSP_VALID(rsp_valid[0]), .iRSP_READY(rsp_ready[0]), .oRSP_RDATA(rsp_rdata[0]), .oRSP_ERR(rsp_err[0]),
      .oRAM_CE(ram_ce[0]), .oRAM_RD(ram_rd[0]), .oRAM_WR(ram_wr[0]), .oRAM_ADDR(ram_addr[0]),
      .iRAM_DATA(ram_rdata[0]), .oRAM_DATA(ram_wdata[0])
   );

   dmem_ctrl #(.ADDR_W(8), .RD_LAT(2)) u1 (
      .iCLK(clk), .iRST(rst[1]), .iREQ_VALID(req_valid[1]), .oREQ_READY(req_ready[1]),
      .iREQ_WE(req_we[1]), .iREQ_FUNC3(req_f3[1]), .iREQ_ADDR(req_addr[1]), .iREQ_WDATA(req_wdata[1]),
      .oRSP_VALID(rsp_valid[1]), .iRSP_READY(rsp_ready[1]), .oRSP_RDATA(rsp_rdata[1]), .oRSP_ERR(rsp_err[1]),
      .oRAM_CE(ram_ce[1]), .oRAM_RD(ram_rd[1]), .oRAM_WR(ram_wr[1]), .oRAM_ADDR(ram_addr[1]),
      .iRAM_DATA(ram_rdata[1]), .oRAM_DATA(ram_wdata[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model: read data appears RD_LAT cycles after the RD strobe edge.
   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (poke_en[d]) mem[d][poke_a[d]] <= poke_v[d];
         else if (ram_ce[d] && ram_wr[d]) mem[d][ram_addr[d]] <= ram_wdata[d];
         if (ram_ce[d] && ram_rd[d]) rd_pipe[d][0] <= mem[d][ram_addr[d]];
         rd_pipe[d][1] <= rd_pipe[d][0];
      end
   end

   always_comb begin
      ram_rdata[0] = rd_pipe[0][0];
      ram_rdata[1] = rd_pipe[1][1];
   end

   task automatic poke(input int d, input logic [7:0] a, input logic [31:0] v);
      @(negedge clk);
      poke_en[d] = 1'b1; poke_a[d] = a; poke_v[d] = v;
      @(posedge clk); #1;
      poke_en[d] = 1'b0;
   endtask

   // Issue one request with iRSP_READY=1 and record strobe/response timing
   // in cycles after the accept edge.
   task automatic do_req(input int d, input logic we, input logic [2:0] f3,
                         input logic [9:0] addr, input logic [31:0] wd);
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = we; req_f3[d] = f3; req_addr[d] = addr; req_wdata[d] = wd;
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      t_rd = -1; t_wr = -1; t_vld = -1; n_rd = 0; n_wr = 0; n_ce = 0;
      wr_data = '0; wr_addr = '0; rdata = '0; err = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge clk);
         if (ram_ce[d]) n_ce++;
         if (ram_rd[d]) begin if (t_rd < 0) t_rd = k; n_rd++; end
         if (ram_wr[d]) begin if (t_wr < 0) t_wr = k; n_wr++; wr_data = ram_wdata[d]; wr_addr = ram_addr[d]; end
         if (rsp_valid[d]) begin t_vld = k; rdata = rsp_rdata[d]; err = rsp_err[d]; break; end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst[0] = 1'b1; rst[1] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0; rst[1] = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready[0] !== 1'b1) begin n_bad++; $display("FAIL reset_ready0: got %b want 1", req_ready[0]); end
      n_cmp++; if (req_ready[1] !== 1'b1) begin n_bad++; $display("FAIL reset_ready1: got %b want 1", req_ready[1]); end
      n_cmp++; if (rsp_valid[0] !== 1'b0 || rsp_err[0] !== 1'b0) begin n_bad++; $display("FAIL reset_rsp: got valid=%b err=%b want 0/0", rsp_valid[0], rsp_err[0]); end
      n_cmp++; if (rsp_rdata[0] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", rsp_rdata[0]); end
      n_cmp++; if ({ram_ce[0], ram_rd[0], ram_wr[0]} !== 3'b000) begin n_bad++; $display("FAIL reset_strobes: got %b want 000", {ram_ce[0], ram_rd[0], ram_wr[0]}); end
      n_cmp++; if (ram_addr[0] !== 8'h0 || ram_wdata[0] !== 32'h0) begin n_bad++; $display("FAIL reset_ram_bus: got addr=%h data=%h want 0/0", ram_addr[0], ram_wdata[0]); end
   endtask

   task automatic test_sw();
      do_req(0, 1'b1, F3_W, 10'h010, 32'hDEADBEEF);
      n_cmp++; if (t_wr !== 1) begin n_bad++; $display("FAIL sw_wr_cycle: got %0d want 1", t_wr); end
      n_cmp++; if (wr_addr !== 8'h04) begin n_bad++; $display("FAIL sw_addr: got %h want 04", wr_addr); end
      n_cmp++; if (wr_data !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_data: got %h want deadbeef", wr_data); end
      n_cmp++; if (n_rd !== 0) begin n_bad++; $display("FAIL sw_no_rd: got %0d rd cycles want 0", n_rd); end
      n_cmp++; if (t_vld !== 2 || err !== 1'b0) begin n_bad++; $display("FAIL sw_resp: got vld@%0d err=%b want 2/0", t_vld, err); end
      n_cmp++; if (mem[0][4] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_mem: got %h want deadbeef", mem[0][4]); end
      do_req(0, 1'b1, F3_W, 10'h3FC, 32'h0BADF00D);
      n_cmp++; if (wr_addr !== 8'hFF || mem[0][255] !== 32'h0BADF00D) begin n_bad++; $display("FAIL sw_top_addr: got addr=%h mem=%h want ff/0badf00d", wr_addr, mem[0][255]); end
   endtask

   task automatic test_rmw();
      poke(0, 8'h04, 32'h11223344);
      do_req(0, 1'b1, F3_B, 10'h012, 32'h000000AB);
      n_cmp++; if (t_rd !== 1 || t_wr !== 3 || t_vld !== 4) begin n_bad++; $display("FAIL sb_timing: got rd@%0d wr@%0d vld@%0d want 1/3/4", t_rd, t_wr, t_vld); end
      n_cmp++; if (wr_data !== 32'h11AB3344) begin n_bad++; $display("FAIL sb_data: got %h want 11ab3344", wr_data); end
      n_cmp++; if (rdata !== 32'h0 || err !== 1'b0) begin n_bad++; $display("FAIL sb_resp: got rdata=%h err=%b want 0/0", rdata, err); end
      poke(0, 8'h05, 32'hCAFEF00D);
      do_req(0, 1'b1, F3_H, 10'h016, 32'h55551234);
      n_cmp++; if (wr_data !== 32'h1234F00D || wr_addr !== 8'h05) begin n_bad++; $display("FAIL sh_data: got %h@%h want 1234f00d@05", wr_data, wr_addr); end
      do_req(0, 1'b1, F3_B, 10'h014, 32'hFFFFFF77);
      n_cmp++; if (mem[0][5] !== 32'h1234F077) begin n_bad++; $display("FAIL sb_lane0_mem: got %h want 1234f077", mem[0][5]); end
   endtask

   task automatic test_loads();
      poke(0, 8'h04, 32'h80FF7F01);
      do_req(0, 1'b0, F3_B, 10'h013, 32'h0);
      n_cmp++; if (rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_13: got %h want ffffff80", rdata); end
      n_cmp++; if (t_rd !== 1 || t_vld !== 3 || n_wr !== 0) begin n_bad++; $display("FAIL load_timing: got rd@%0d vld@%0d wr=%0d want 1/3/0", t_rd, t_vld, n_wr); end
      do_req(0, 1'b0, F3_BU, 10'h013, 32'h0);
      n_cmp++; if (rdata !== 32'h00000080) begin n_bad++; $display("FAIL lbu_13: got %h want 00000080", rdata); end
      do_req(0, 1'b0, F3_H, 10'h012, 32'h0);
      n_cmp++; if (rdata !== 32'hFFFF80FF) begin n_bad++; $display("FAIL lh_12: got %h want ffff80ff", rdata); end
      do_req(0, 1'b0, F3_HU, 10'h010, 32'h0);
      n_cmp++; if (rdata !== 32'h00007F01) begin n_bad++; $display("FAIL lhu_10: got %h want 00007f01", rdata); end
      do_req(0, 1'b0, F3_H, 10'h010, 32'h0);
      n_cmp++; if (rdata !== 32'h00007F01) begin n_bad++; $display("FAIL lh_10: got %h want 00007f01", rdata); end
      do_req(0, 1'b0, F3_B, 10'h011, 32'h0);
      n_cmp++; if (rdata !== 32'h0000007F) begin n_bad++; $display("FAIL lb_11: got %h want 0000007f", rdata); end
      do_req(0, 1'b0, F3_W, 10'h010, 32'h0);
      n_cmp++; if (rdata !== 32'h80FF7F01 || err !== 1'b0) begin n_bad++; $display("FAIL lw_10: got %h err=%b want 80ff7f01/0", rdata, err); end
   endtask

   task automatic test_errors();
      do_req(0, 1'b1, F3_H, 10'h011, 32'h1234);
      n_cmp++; if (t_vld !== 1 || err !== 1'b1 || n_ce !== 0) begin n_bad++; $display("FAIL err_sh_11: got vld@%0d err=%b ce=%0d want 1/1/0", t_vld, err, n_ce); end
      do_req(0, 1'b0, F3_W, 10'h012, 32'h0);
      n_cmp++; if (t_vld !== 1 || err !== 1'b1 || n_ce !== 0 || rdata !== 32'h0) begin n_bad++; $display("FAIL err_lw_12: got vld@%0d err=%b ce=%0d rdata=%h want 1/1/0/0", t_vld, err, n_ce, rdata); end
      do_req(0, 1'b0, 3'd3, 10'h010, 32'h0);
      n_cmp++; if (t_vld !== 1 || err !== 1'b1) begin n_bad++; $display("FAIL err_load_f3: got vld@%0d err=%b want 1/1", t_vld, err); end
      do_req(0, 1'b1, F3_BU, 10'h010, 32'h0);
      n_cmp++; if (t_vld !== 1 || err !== 1'b1 || n_wr !== 0) begin n_bad++; $display("FAIL err_store_f3: got vld@%0d err=%b wr=%0d want 1/1/0", t_vld, err, n_wr); end
      do_req(0, 1'b0, F3_HU, 10'h013, 32'h0);
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_lhu_13: got err=%b want 1", err); end
   endtask

   task automatic test_backpressure();
      int k;
      @(negedge clk);
      req_valid[0] = 1'b1; req_we[0] = 1'b0; req_f3[0] = F3_W; req_addr[0] = 10'h010; req_wdata[0] = 32'h0;
      rsp_ready[0] = 1'b0;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      k = 0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         if (rsp_valid[0]) begin k = i; break; end
      end
      n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL bp_first_valid: got cycle %0d want 3", k); end
      // A store to the same word is offered during backpressure; it must not be taken.
      req_valid[0] = 1'b1; req_we[0] = 1'b1; req_f3[0] = F3_W; req_addr[0] = 10'h010; req_wdata[0] = 32'h0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         n_cmp++; if (rsp_valid[0] !== 1'b1 || rsp_rdata[0] !== 32'h80FF7F01 || req_ready[0] !== 1'b0) begin
            n_bad++; $display("FAIL bp_hold%0d: got valid=%b rdata=%h ready=%b want 1/80ff7f01/0", i, rsp_valid[0], rsp_rdata[0], req_ready[0]);
         end
      end
      rsp_ready[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      @(negedge clk);
      n_cmp++; if (rsp_valid[0] !== 1'b0 || req_ready[0] !== 1'b1 || ram_ce[0] !== 1'b0) begin
         n_bad++; $display("FAIL bp_retire: got valid=%b ready=%b ce=%b want 0/1/0", rsp_valid[0], req_ready[0], ram_ce[0]);
      end
      repeat (3) @(posedge clk);
      #1;
      n_cmp++; if (mem[0][4] !== 32'h80FF7F01) begin n_bad++; $display("FAIL bp_no_accept_mem: got %h want 80ff7f01", mem[0][4]); end
   endtask

   task automatic test_reset_rmw(input int d, input int rst_at);
      int wr_seen;
      poke(d, 8'h04, 32'h11223344);
      @(negedge clk);
      req_valid[d] = 1'b1; req_we[d] = 1'b1; req_f3[d] = F3_B; req_addr[d] = 10'h012; req_wdata[d] = 32'hAB;
      rsp_ready[d] = 1'b1;
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      wr_seen = 0;
      for (int k = 1; k <= rst_at; k++) begin
         @(negedge clk);
         if (k == rst_at) begin rst[d] = 1'b1; #1; end
         if (ram_wr[d]) wr_seen++;
      end
      n_cmp++; if (ram_ce[d] !== 1'b0 || ram_wr[d] !== 1'b0) begin n_bad++; $display("FAIL rst%0d_gate: got ce=%b wr=%b want 0/0", d, ram_ce[d], ram_wr[d]); end
      @(negedge clk);
      rst[d] = 1'b0;
      @(negedge clk);
      n_cmp++; if (req_ready[d] !== 1'b1 || rsp_valid[d] !== 1'b0) begin n_bad++; $display("FAIL rst%0d_idle: got ready=%b valid=%b want 1/0", d, req_ready[d], rsp_valid[d]); end
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         if (ram_wr[d] || rsp_valid[d]) wr_seen++;
      end
      n_cmp++; if (wr_seen !== 0) begin n_bad++; $display("FAIL rst%0d_no_write: got %0d wr/valid cycles want 0", d, wr_seen); end
      n_cmp++; if (mem[d][4] !== 32'h11223344) begin n_bad++; $display("FAIL rst%0d_mem: got %h want 11223344", d, mem[d][4]); end
   endtask

   task automatic test_rdlat2();
      poke(1, 8'h04, 32'h11223344);
      do_req(1, 1'b1, F3_B, 10'h012, 32'h000000AB);
      n_cmp++; if (t_rd !== 1 || t_wr !== 4 || t_vld !== 5) begin n_bad++; $display("FAIL lat2_sb_timing: got rd@%0d wr@%0d vld@%0d want 1/4/5", t_rd, t_wr, t_vld); end
      n_cmp++; if (wr_data !== 32'h11AB3344) begin n_bad++; $display("FAIL lat2_sb_data: got %h want 11ab3344", wr_data); end
      do_req(1, 1'b0, F3_B, 10'h012, 32'h0);
      n_cmp++; if (t_vld !== 4 || rdata !== 32'hFFFFFFAB) begin n_bad++; $display("FAIL lat2_lb: got vld@%0d rdata=%h want 4/ffffffab", t_vld, rdata); end
      do_req(1, 1'b1, F3_W, 10'h020, 32'h01020304);
      n_cmp++; if (t_wr !== 1 || t_vld !== 2) begin n_bad++; $display("FAIL lat2_sw: got wr@%0d vld@%0d want 1/2", t_wr, t_vld); end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; req_valid[d] = 1'b0; req_we[d] = 1'b0; req_f3[d] = '0;
         req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b1;
         poke_en[d] = 1'b0; poke_a[d] = '0; poke_v[d] = '0;
      end
      test_reset();
      test_sw();
      test_rmw();
      test_loads();
      test_errors();
      test_backpressure();
      test_reset_rmw(0, 2);
      test_reset_rmw(0, 3);
      test_rdlat2();
      test_reset_rmw(1, 3);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
